// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared types and constants for the tank sprite renderer
package tank_pkg;
  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_RIGHT = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  localparam int SPRITE_DIM   = 16;
  localparam int SPRITE_ROWS  = 128;
  localparam int FRAME_STRIDE = 32;
  localparam logic [4:0] TRANSPARENT_IDX = 5'd0;

  // First ROM row of the 16x16 frame for a direction and animation phase.
  function automatic logic [6:0] row_base(input dir_t dir, input logic anim);
    return 7'(int'(dir) * FRAME_STRIDE + int'(anim) * SPRITE_DIM);
  endfunction
endpackage

// File: rtl/anim_ticker.sv
// rtl/anim_ticker.sv - frame-pulse divider with enable, clear and a toggling output
module anim_ticker #(
  parameter int   DIV  = 4,
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic en,
  input  logic clr,
  output logic toggle
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tog_q, tog_d;

  always_comb begin
    cnt_d = cnt_q;
    tog_d = tog_q;
    if (tick) begin
      if (clr) begin
        cnt_d = '0;
        tog_d = INIT;
      end else if (en) begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d = '0;
          tog_d = ~tog_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tog_q <= INIT;
    end else begin
      cnt_q <= cnt_d;
      tog_q <= tog_d;
    end
  end

  assign toggle = tog_q;
endmodule

// File: rtl/tank_sprite_renderer.sv
// rtl/tank_sprite_renderer.sv - per-pixel tank sprite stage; TANK_BLINK_EN adds blinking
module tank_sprite_renderer
  import tank_pkg::*;
#(
  parameter int ANIM_DIV   = 4,
  parameter int BLINK_DIV  = 8,
  parameter int SCALE_LOG2 = 0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] tank_x,
  input  logic [9:0] tank_y,
  input  logic [1:0] direction,
  input  logic       moving,
  input  logic       blink,
  input  logic [4:0] rgb [0:SPRITE_ROWS-1][0:SPRITE_DIM-1],
  output logic [4:0] pixel_idx,
  output logic       pixel_valid
);
  localparam int BOX = SPRITE_DIM << SCALE_LOG2;

  logic [9:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  dir_t       dir_q, dir_d;
  logic       moving_q, moving_d;
  logic       anim, visible;

  logic       hit_q, hit_d;
  logic [3:0] lx_q, lx_d, ly_q, ly_d;
  logic [6:0] base_q, base_d;
  logic [4:0] pix_idx_q, pix_idx_d;
  logic       pix_valid_q, pix_valid_d;

  logic [10:0] dx, dy;
  logic [4:0]  idx;

  // Shadow copies only move at frame_start so a frame never tears.
  always_comb begin
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    dir_d    = dir_q;
    moving_d = moving_q;
    if (frame_start) begin
      pos_x_d  = tank_x;
      pos_y_d  = tank_y;
      dir_d    = dir_t'(direction);
      moving_d = moving;
    end
  end

  anim_ticker #(.DIV(ANIM_DIV), .INIT(1'b0)) u_anim (
    .clk    (Clk),
    .reset  (Reset),
    .tick   (frame_start),
    .en     (moving_q),
    .clr    (1'b0),
    .toggle (anim)
  );

`ifdef TANK_BLINK_EN
  anim_ticker #(.DIV(BLINK_DIV), .INIT(1'b1)) u_blink (
    .clk    (Clk),
    .reset  (Reset),
    .tick   (frame_start),
    .en     (blink),
    .clr    (!blink),
    .toggle (visible)
  );
`else
  localparam int unused_blink_div = BLINK_DIV;
  logic unused_blink;
  assign unused_blink = blink;
  assign visible      = 1'b1;
`endif

  // A negative offset shows up as bit 10 set, so off-screen parts never hit.
  always_comb begin
    dx     = {1'b0, DrawX} - {1'b0, pos_x_q};
    dy     = {1'b0, DrawY} - {1'b0, pos_y_q};
    hit_d  = !dx[10] && ({1'b0, dx[9:0]} < 11'(BOX)) &&
             !dy[10] && ({1'b0, dy[9:0]} < 11'(BOX)) && visible;
    lx_d   = 4'(dx[9:0] >> SCALE_LOG2);
    ly_d   = 4'(dy[9:0] >> SCALE_LOG2);
    base_d = row_base(dir_q, anim);
  end

  always_comb begin
    idx         = rgb[base_q + {3'b000, ly_q}][lx_q];
    pix_valid_d = hit_q && (idx != TRANSPARENT_IDX);
    pix_idx_d   = pix_valid_d ? idx : TRANSPARENT_IDX;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      dir_q       <= DIR_UP;
      moving_q    <= 1'b0;
      hit_q       <= 1'b0;
      lx_q        <= '0;
      ly_q        <= '0;
      base_q      <= '0;
      pix_idx_q   <= TRANSPARENT_IDX;
      pix_valid_q <= 1'b0;
    end else begin
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      dir_q       <= dir_d;
      moving_q    <= moving_d;
      hit_q       <= hit_d;
      lx_q        <= lx_d;
      ly_q        <= ly_d;
      base_q      <= base_d;
      pix_idx_q   <= pix_idx_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign pixel_idx   = pix_idx_q;
  assign pixel_valid = pix_valid_q;
endmodule

// File: tb/tb_tank_sprite_renderer.sv
// tb/tb_tank_sprite_renderer.sv - self-checking bench with a frame-level reference model
module tb_tank_sprite_renderer;
  localparam int ANIM_DIV   = 4;
  localparam int BLINK_DIV  = 8;
  localparam int SCALE_LOG2 = 0;
  localparam int BOX        = 16 << SCALE_LOG2;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_start = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, tank_x = '0, tank_y = '0;
  logic [1:0] direction = 2'd1;
  logic       moving = 1'b0, blink = 1'b0;
  logic [4:0] rom [0:127][0:15];
  logic [4:0] pixel_idx;
  logic       pixel_valid;

  int tests = 0;
  int fails = 0;

  tank_sprite_renderer #(.ANIM_DIV(ANIM_DIV), .BLINK_DIV(BLINK_DIV), .SCALE_LOG2(SCALE_LOG2)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .tank_x(tank_x), .tank_y(tank_y),
    .direction(direction), .moving(moving), .blink(blink), .rgb(rom),
    .pixel_idx(pixel_idx), .pixel_valid(pixel_valid)
  );

  always #5 Clk = ~Clk;

  // Model state: latched tank values plus counts of pulses seen while moving/blinking.
  int   m_px, m_py, m_dir, m_mov, m_mcnt, m_bcnt;
  bit   m_started = 1'b0;
  logic [5:0] e_s1 = '0, e_out = '0;

  function automatic logic [5:0] model_pix();
    int dx, dy, anim, row;
    bit vis;
    logic [4:0] v;
    dx   = int'(DrawX) - m_px;
    dy   = int'(DrawY) - m_py;
    anim = (m_mcnt / ANIM_DIV) % 2;
    vis  = 1'b1;
`ifdef TANK_BLINK_EN
    vis  = ((m_bcnt / BLINK_DIV) % 2) == 0;
`endif
    if (dx < 0 || dx >= BOX || dy < 0 || dy >= BOX || !vis) return 6'd0;
    row = m_dir * 32 + anim * 16 + (dy >> SCALE_LOG2);
    v   = rom[row][dx >> SCALE_LOG2];
    if (v == 5'd0) return 6'd0;
    return {1'b1, v};
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      m_px = 0; m_py = 0; m_dir = 1; m_mov = 0; m_mcnt = 0; m_bcnt = 0;
      e_s1 = '0; e_out = '0; m_started = 1'b1;
    end else begin
      e_out = e_s1;
      e_s1  = model_pix();
      if (frame_start) begin
        if (m_mov != 0) m_mcnt++;
        if (blink) m_bcnt++; else m_bcnt = 0;
        m_px = int'(tank_x); m_py = int'(tank_y); m_dir = int'(direction); m_mov = int'(moving);
      end
    end
  end

  always @(negedge Clk) begin
    if (m_started) begin
      tests++;
      if (pixel_idx !== e_out[4:0] || pixel_valid !== e_out[5]) begin
        fails++;
        if (fails < 20)
          $display("FAIL model_cmp t=%0t got idx=%0d valid=%0b want idx=%0d valid=%0b",
                   $time, pixel_idx, pixel_valid, e_out[4:0], e_out[5]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  task automatic check_lit(input string name, input logic [4:0] ei, input logic ev);
    tests++;
    if (pixel_idx !== ei || pixel_valid !== ev) begin
      fails++;
      $display("FAIL %s got idx=%0d valid=%0b want idx=%0d valid=%0b", name, pixel_idx, pixel_valid, ei, ev);
    end
  endtask

  task automatic beam(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    step(2);
  endtask

  initial begin
    int lat_x, lat_y;
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 16; c++)
        rom[r][c] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    rom[34][7] = 5'd9;  rom[34][0] = 5'd0;  rom[7][2]  = 5'd9;
    rom[109][7] = 5'd9; rom[1][5]  = 5'd10; rom[17][5] = 5'd9;

    Reset = 1'b1;
    step(2);
    check_lit("reset_out", 5'd0, 1'b0);
    Reset = 1'b0;

    tank_x = 10'd100; tank_y = 10'd50; direction = 2'd1; moving = 1'b0;
    frame();
    beam(107, 52); check_lit("up_row34_col7", 5'd9, 1'b1);
    beam(100, 52); check_lit("transparent_col0", 5'd0, 1'b0);
    beam(116, 52); check_lit("outside_box", 5'd0, 1'b0);
    beam(115, 52); check_lit("box_right_edge", rom[34][15], rom[34][15] != 5'd0);

    direction = 2'd0; frame();
    beam(102, 57); check_lit("left_row7_col2", 5'd9, 1'b1);
    direction = 2'd3; frame();
    beam(107, 63); check_lit("down_row109_col7", 5'd9, 1'b1);

    direction = 2'd0; moving = 1'b1; frame();
    beam(105, 51); check_lit("anim_phase0", 5'd10, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      frame(); step(2);
      if (k == 3) check_lit("anim_before_wrap", 5'd10, 1'b1);
    end
    check_lit("anim_phase1", 5'd9, 1'b1);
    moving = 1'b0;
    for (int k = 0; k < 11; k++) begin
      frame(); step(2);
      check_lit("anim_hold", 5'd9, 1'b1);
    end

    direction = 2'd2; step(3);
    check_lit("no_tear_midframe", 5'd9, 1'b1);
    Reset = 1'b1; step(1);
    check_lit("reset_midline", 5'd0, 1'b0);
    Reset = 1'b0;

`ifdef TANK_BLINK_EN
    tank_x = 10'd100; tank_y = 10'd50; direction = 2'd1; moving = 1'b0; blink = 1'b1;
    DrawX = 10'd107; DrawY = 10'd52;
    for (int k = 1; k <= 24; k++) begin
      frame(); step(2);
      check_lit($sformatf("blink_frame%0d", k), ((k / 8) % 2 == 0) ? 5'd9 : 5'd0, (k / 8) % 2 == 0);
    end
    blink = 1'b0; frame(); step(2);
    check_lit("blink_off", 5'd9, 1'b1);
`endif

    lat_x = 100; lat_y = 50;
    for (int i = 0; i < 4000; i++) begin
      Reset       = ($urandom_range(0, 499) == 0);
      frame_start = ($urandom_range(0, 19) == 0);
      if (frame_start) begin
        tank_x    = 10'($urandom_range(0, 1023));
        tank_y    = 10'($urandom_range(0, 1023));
        direction = 2'($urandom_range(0, 3));
        moving    = 1'($urandom_range(0, 1));
        blink     = ($urandom_range(0, 3) != 0);
        lat_x = int'(tank_x); lat_y = int'(tank_y);
      end
      DrawX = 10'(lat_x + int'($urandom_range(0, 24)) - 4);
      DrawY = 10'(lat_y + int'($urandom_range(0, 24)) - 4);
      step(1);
    end
    Reset = 1'b0; frame_start = 1'b0;
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
